// File: rtl/fir_filter.sv
// -----------------------------------------------------------------------------
// fir_filter
//   11-tap direct-form FIR low-pass filter on a signed sample stream.
//   It accepts one sample per clock and produces one filtered sample per clock.
//   There is no handshake. A new sample is consumed on every rising edge.
//
//   The output is registered. The sample presented at edge k already
//   contributes h0*x to y right after edge k.
//
// Ports
//   clk    in   1        single clock, rising edge
//   reset  in   1        asynchronous, active-low; clears delay line and y
//   x      in   DATA_W   signed input sample
//   y      out  DATA_W   signed filtered output (registered)
//
// Build option
//   FIR_SAT_EN  when defined, the shifted accumulator is clamped to the signed
//               DATA_W range before it drives y. When undefined, the low
//               DATA_W bits are kept, so the output wraps in two's complement.
// -----------------------------------------------------------------------------
module fir_filter #(
  parameter int                       DATA_W = 16,
  parameter int                       COEF_W = 16,
  parameter int                       TAPS   = 11,
  // h0..h10, h0 in the least-significant COEF_W bits
  parameter logic [TAPS*COEF_W-1:0]   COEFFS = {16'd1, 16'd2, 16'd3, 16'd4,
                                                16'd5, 16'd6, 16'd5, 16'd4,
                                                16'd3, 16'd2, 16'd1},
  parameter int                       SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  // Four guard bits absorb the growth from summing 11 products.
  localparam int ACC_W = DATA_W + COEF_W + 4;

  // d[0] holds the previous sample, and d[TAPS-2] holds the oldest one.
  logic [DATA_W-1:0]       d [0:TAPS-2];
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0]       y_next;

  // Multiply-accumulate over the current sample and the delay line.
  // Both operands are sign-extended to the accumulator width before the
  // multiply, so the product and the sum stay exact.
  // NOTE: the first statement assigns acc, so every path writes it and no
  // latch can be inferred.
  always_comb begin
    acc = ACC_W'($signed(x)) * ACC_W'($signed(COEFFS[COEF_W-1:0]));
    for (int i = 1; i < TAPS; i++) begin
      acc = acc + ACC_W'($signed(d[i-1]))
                * ACC_W'($signed(COEFFS[i*COEF_W +: COEF_W]));
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W-1));

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX) begin
      y_next = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      y_next = SAT_MIN[DATA_W-1:0];
    end else begin
      y_next = shifted[DATA_W-1:0];
    end
  end
`else
  // Keeping only the low bits gives two's-complement wrap on overflow.
  assign y_next = DATA_W'(acc >>> SHIFT);
`endif

  // NOTE: the delay line is reset on purpose. A reset must discard all
  // history so that the output after reset matches the power-up behaviour.
  // NOTE: sequential state uses non-blocking assignments. Each tap then
  // reads the value its neighbour held before this edge, which is what makes
  // the delay line shift by exactly one position per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= '0;
      for (int i = 0; i < TAPS-1; i++) begin
        d[i] <= '0;
      end
    end else begin
      y    <= y_next;
      d[0] <= x;
      for (int i = 1; i < TAPS-1; i++) begin
        d[i] <= d[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_filter
//   Directed self-checking bench for fir_filter. The expected values are
//   hand-computed from the coefficient set {1,2,3,4,5,6,5,4,3,2,1}.
//   The bench drives inputs 1 time unit after each rising edge and samples y
//   at the same point.
// -----------------------------------------------------------------------------
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x;
  logic [15:0] y;

  int checks = 0;
  int errors = 0;

  fir_filter dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Present one sample, let the edge take it, then settle past the edge.
  task automatic drive(input logic [15:0] v);
    x = v;
    @(posedge clk);
    #1;
  endtask

  int imp_exp  [13] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 0};
  int step_exp [14] = '{1, 3, 6, 10, 15, 21, 26, 30, 33, 35, 36, 36, 36, 36};

  initial begin
    reset = 1'b0;
    x     = '0;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", y, 16'd0);
    reset = 1'b1;

    // Impulse response.
    for (int i = 0; i < 13; i++) begin
      drive((i == 0) ? 16'd1 : 16'd0);
      check($sformatf("impulse[%0d]", i), y, 16'(imp_exp[i]));
    end

    // Step response.
    for (int i = 0; i < 14; i++) begin
      drive(16'd1);
      check($sformatf("step[%0d]", i), y, 16'(step_exp[i]));
    end

    // Asynchronous reset between edges while y is nonzero.
    reset = 1'b0;
    #1;
    check("async_reset_immediate", y, 16'd0);
    @(posedge clk);
    #1;
    check("async_reset_held", y, 16'd0);
    reset = 1'b1;

    // Ramp from a clean delay line. After ten edges, y = 36*x - 180.
    x = '0;
    for (int k = 1; k <= 20; k++) begin
      drive(16'(k));
      if (k >= 11) check($sformatf("ramp[x=%0d]", k), y, 16'(36*k - 180));
    end

    // Reset in the middle of a ramp, asserted at x=15.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      drive(16'(k));
    end
    check("ramp2[x=14]", y, 16'd324);
    x     = 16'd15;
    reset = 1'b0;
    #1;
    check("midstream_reset", y, 16'd0);
    @(posedge clk);
    #1;
    check("midstream_reset_edge", y, 16'd0);
    reset = 1'b1;
    drive(16'd16);
    check("resume[16]", y, 16'd16);
    drive(16'd17);
    check("resume[17]", y, 16'd49);
    drive(16'd18);
    check("resume[18]", y, 16'd100);

    // Positive overflow with x = 32767 held.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    drive(16'h7FFF);
    check("ovf_pos_first", y, 16'h7FFF);
    drive(16'h7FFF);
`ifdef FIR_SAT_EN
    check("ovf_pos_second", y, 16'h7FFF);
`else
    check("ovf_pos_second", y, 16'h7FFD);
`endif
    for (int i = 2; i < 12; i++) begin
      drive(16'h7FFF);
    end
`ifdef FIR_SAT_EN
    check("ovf_pos_steady", y, 16'h7FFF);
`else
    check("ovf_pos_steady", y, 16'hFFDC);
`endif

    // Switch to x = -32768. The first edge is a transient that still
    // overflows in the positive direction.
    drive(16'h8000);
`ifdef FIR_SAT_EN
    check("ovf_transition", y, 16'h7FFF);
`else
    check("ovf_transition", y, 16'hFFDD);
`endif
    for (int i = 1; i < 12; i++) begin
      drive(16'h8000);
    end
`ifdef FIR_SAT_EN
    check("ovf_neg_steady", y, 16'h8000);
`else
    check("ovf_neg_steady", y, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
